min_max_ctrl: RTL and testbench
===============================

// Module: min_max_ctrl
// PURPOSE
//  Upstream input stage of min_max_top. Conditions raw board buttons and switches,
//  and holds the editable min/max/value registers with the invariant min <= max.
//  Generates the low-intensity oscillation strobe. Outputs drive min_max_top
//  com_i/min_i/max_i/val_i/osc_i directly; all outputs are registered.
// PARAMETERS
//  VALSIZE          4   width of min/max/value
//  DEBOUNCE_CYCLES  4   consecutive stable cycles before a debounced level changes (>=1)
//  OSC_PERIOD       8   osc_o period in clk cycles (>=2)
//  OSC_HIGH         2   cycles per period with osc_o=1 (1..OSC_PERIOD-1)
//  REPEAT_DELAY     20  hold cycles before first auto-repeat (used only with macro)
//  REPEAT_RATE      10  cycles between auto-repeats (used only with macro)
// PORTS
//  clk_i       in   1        system clock, rising edge
//  rst_i       in   1        reset, asynchronous, active-high
//  btn_up_i    in   1        raw increment button, async, may bounce
//  btn_down_i  in   1        raw decrement button, async, may bounce
//  btn_sel_i   in   1        raw edit-select button, async, may bounce
//  com_sw_i    in   2        raw mode switches
//  com_o       out  2        synchronised mode, to min_max_top.com_i
//  min_o       out  VALSIZE  min register
//  max_o       out  VALSIZE  max register
//  val_o       out  VALSIZE  value register
//  osc_o       out  1        oscillation strobe
//  sel_o       out  2        edit state: 00 VAL, 01 MIN, 10 MAX (11 never driven)
// BEHAVIOUR
//  - Reset (async): min_o=0, max_o=2**VALSIZE-1, val_o=0, com_o=00, osc_o=0,
//    sel_o=00. All synchroniser, debounce, osc and repeat state cleared.
//    Reset mid-press or mid-debounce: the press is discarded. A button still held
//    at release of reset generates no event until it is released and pressed again.
//  - Each button and com_sw_i bit: 2-FF synchroniser.
//  - Debounce, per button: counter increments while the synced level differs from
//    the debounced level and reloads 0 on any match. The debounced level takes the
//    synced level when the count reaches DEBOUNCE_CYCLES.
//  - Event: 1-cycle pulse on the debounced 0->1 edge.
//  - Latency, pin edge to register update: 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - com_o = synced com_sw_i, registered once (latency 3 cycles). No debounce.
//  - FSM on sel event: VAL -> MIN -> MAX -> VAL.
//  - Priority in one cycle: sel > up/down. With a sel event, up/down events in the
//    same cycle are dropped. up and down events together are both dropped.
//  - VAL: up -> val+1, saturates at 2**VALSIZE-1. down -> val-1, saturates at 0.
//    val is NOT clamped to [min,max]; out-of-range handling belongs to min_max_top.
//  - MIN: up applies only if min_o < max_o. down saturates at 0.
//  - MAX: down applies only if max_o > min_o. up saturates at 2**VALSIZE-1.
//  - Arithmetic is VALSIZE-bit unsigned; never wraps.
//  - osc: free-running counter 0..OSC_PERIOD-1, wraps to 0. osc_o <= (cnt < OSC_HIGH).
//    First high cycle is the first clk after reset release.
// CONFIGURATION
//  MIN_MAX_CTRL_AUTOREPEAT_EN defined:
//    - up/down held debounced-high generates the normal edge event.
//    - After REPEAT_DELAY further held cycles, a further event fires, then one every
//      REPEAT_RATE cycles while held.
//    - The repeat counter clears on release, on sel event, and on reset.
//    - Repeats obey the same priority and saturation rules.
//  Undefined: exactly one event per press. REPEAT_* are ignored; no repeat logic
//    is synthesised.
// TESTING (VALSIZE=4, DEBOUNCE_CYCLES=4, OSC_PERIOD=8, OSC_HIGH=2)
//  1. Reset -> min 0, max 15, val 0, com 00, sel 00. With rst_i asserted mid-debounce,
//     outputs return to the reset values immediately, without waiting for a clock.
//  2. Three clean up presses of 10 cycles each -> val 3, each update 7 cycles after
//     the edge. A 2-cycle glitch on btn_up_i -> val unchanged.
//  3. sel x2 (sel 10), down x4 -> max 11. sel x2 (sel 01), up x15 -> min stops at 11.
//     down x2 while sel=10 -> max stays 11.
//  4. Saturation: val=15, up -> 15. val=0, down -> 0. up+down events in the same
//     cycle -> no change. sel+up in the same cycle -> sel advances, value unchanged.
//  5. osc_o after reset: 1,1,0,0,0,0,0,0 repeating, period 8. com_sw_i=11 -> com_o=11
//     after 3 cycles.
//  6. Hold up 100 cycles from val 0. With MIN_MAX_CTRL_AUTOREPEAT_EN: 1 edge event,
//     a repeat 20 cycles later, then one every 10 -> val = 1 + 1 + floor((100-7-20)/10) = 9.
//     Without the macro -> val = 1.

Source files
------------

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: synchronises and debounces the board buttons and switches, and holds the
//   editable min/max/value registers with min <= max. It also generates the osc strobe.
// Latency: pin edge to register update is 2 + DEBOUNCE_CYCLES + 1 cycles. com_o lags 3 cycles.
// Backpressure: none; every output is registered and updates unconditionally.
// Optional auto-repeat on held up/down buttons: define MIN_MAX_CTRL_AUTOREPEAT_EN.
module min_max_ctrl #(
  parameter int VALSIZE         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OSC_PERIOD      = 8,
  parameter int OSC_HIGH        = 2
`ifdef MIN_MAX_CTRL_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_RATE     = 10
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_up_i,
  input  logic               btn_down_i,
  input  logic               btn_sel_i,
  input  logic [1:0]         com_sw_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o,
  output logic [1:0]         sel_o
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int OW = $clog2(OSC_PERIOD);
  localparam logic [OW-1:0] OSC_LAST = OW'(OSC_PERIOD - 1);
  localparam logic [OW-1:0] OSC_HI   = OW'(OSC_HIGH);
  localparam logic [VALSIZE-1:0] VMAX = '1;
  localparam logic [VALSIZE-1:0] VZERO = '0;

  // Button bit order in all 3-bit vectors: [0] up, [1] down, [2] sel.
  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_SEL = 2;

  typedef enum logic [1:0] {
    S_VAL = 2'b00,
    S_MIN = 2'b01,
    S_MAX = 2'b10
  } sel_t;

  logic [2:0]         r_btn_s1;
  logic [2:0]         r_btn_s2;
  logic [1:0]         r_com_s1;
  logic [1:0]         r_com_s2;
  logic [1:0]         r_com;
  logic [1:0]         r_vld_sh;
  logic [DBW-1:0]     r_db_cnt [3];
  logic [2:0]         r_deb;
  logic [2:0]         r_deb_d;
  logic [2:0]         r_armed;
  logic [OW-1:0]      r_osc_cnt;
  logic               r_osc;
  sel_t               r_sel;
  logic [VALSIZE-1:0] r_min;
  logic [VALSIZE-1:0] r_max;
  logic [VALSIZE-1:0] r_val;

  logic               w_sync_vld;
  logic [2:0]         w_edge;
  logic [1:0]         w_rep;
  logic               w_sel_evt;
  logic               w_up_evt;
  logic               w_dn_evt;
  logic               w_up;
  logic               w_dn;

  // Two-flop synchronisers for buttons and mode switches, plus the registered com output.
  // r_vld_sh marks when the synchroniser outputs reflect real pin levels after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_com_s1 <= '0;
      r_com_s2 <= '0;
      r_com    <= '0;
      r_vld_sh <= '0;
    end else begin
      r_btn_s1 <= {btn_sel_i, btn_down_i, btn_up_i};
      r_btn_s2 <= r_btn_s1;
      r_com_s1 <= com_sw_i;
      r_com_s2 <= r_com_s1;
      r_com    <= r_com_s2;
      r_vld_sh <= {r_vld_sh[0], 1'b1};
    end
  end

  assign w_sync_vld = r_vld_sh[1];

  // Debounce: the level flips after DEBOUNCE_CYCLES consecutive mismatching cycles.
  // A button is armed only once it has been seen released after reset, so a button
  // held through reset produces no event until it is released and pressed again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_armed <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_s2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
        if (w_sync_vld && !r_btn_s2[i]) r_armed[i] <= 1'b1;
      end
    end
  end

  assign w_edge    = r_deb & ~r_deb_d & r_armed;
  assign w_sel_evt = w_edge[B_SEL];

`ifdef MIN_MAX_CTRL_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);

  logic [RW-1:0] r_rep_cnt [2];
  logic [1:0]    r_rep_ph;

  // Repeat fires REPEAT_DELAY cycles after the press event, then every REPEAT_RATE.
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < 2; i++) begin
      w_rep[i] = r_deb[i] & r_armed[i] &
                 (r_rep_ph[i] ? (r_rep_cnt[i] == R_RATE) : (r_rep_cnt[i] == R_DELAY));
    end
  end

  // Hold-time counters for up/down; cleared on release and on any sel event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
      r_rep_ph <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_deb[i] || w_sel_evt) begin
          r_rep_cnt[i] <= '0;
          r_rep_ph[i]  <= 1'b0;
        end else if (w_rep[i]) begin
          r_rep_cnt[i] <= RW'(1);
          r_rep_ph[i]  <= 1'b1;
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign w_rep = '0;
`endif

  assign w_up_evt = w_edge[B_UP] | w_rep[B_UP];
  assign w_dn_evt = w_edge[B_DN] | w_rep[B_DN];
  // sel wins over up/down; simultaneous up and down cancel each other.
  assign w_up = w_up_evt & ~w_dn_evt & ~w_sel_evt;
  assign w_dn = w_dn_evt & ~w_up_evt & ~w_sel_evt;

  // Edit-state FSM and the min/max/value registers; saturating, never wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sel <= S_VAL;
      r_min <= VZERO;
      r_max <= VMAX;
      r_val <= VZERO;
    end else if (w_sel_evt) begin
      case (r_sel)
        S_VAL:   r_sel <= S_MIN;
        S_MIN:   r_sel <= S_MAX;
        default: r_sel <= S_VAL;
      endcase
    end else begin
      case (r_sel)
        S_VAL: begin
          if (w_up && r_val != VMAX) r_val <= r_val + 1'b1;
          else if (w_dn && r_val != VZERO) r_val <= r_val - 1'b1;
        end
        S_MIN: begin
          if (w_up && r_min < r_max) r_min <= r_min + 1'b1;
          else if (w_dn && r_min != VZERO) r_min <= r_min - 1'b1;
        end
        S_MAX: begin
          if (w_up && r_max != VMAX) r_max <= r_max + 1'b1;
          else if (w_dn && r_max > r_min) r_max <= r_max - 1'b1;
        end
        default: r_sel <= S_VAL;
      endcase
    end
  end

  // Free-running oscillation counter; strobe is high for the first OSC_HIGH counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_osc_cnt <= '0;
      r_osc     <= 1'b0;
    end else begin
      r_osc     <= (r_osc_cnt < OSC_HI);
      r_osc_cnt <= (r_osc_cnt == OSC_LAST) ? '0 : r_osc_cnt + OW'(1);
    end
  end

  assign com_o = r_com;
  assign min_o = r_min;
  assign max_o = r_max;
  assign val_o = r_val;
  assign osc_o = r_osc;
  assign sel_o = r_sel;

endmodule

// File: tb/tb_min_max_ctrl.sv
// Testbench for min_max_ctrl: directed button/switch sequences with hand-computed
// expectations pushed into a scoreboard that a negedge monitor drains by due cycle.
module tb_min_max_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic       sl  = 1'b0;
  logic [1:0] sw  = 2'b00;
  logic [1:0] com_o;
  logic [3:0] min_o;
  logic [3:0] max_o;
  logic [3:0] val_o;
  logic       osc_o;
  logic [1:0] sel_o;

  min_max_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .btn_up_i   (up),
    .btn_down_i (dn),
    .btn_sel_i  (sl),
    .com_sw_i   (sw),
    .com_o      (com_o),
    .min_o      (min_o),
    .max_o      (max_o),
    .val_o      (val_o),
    .osc_o      (osc_o),
    .sel_o      (sel_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observation vector: {com[16:15], osc[14], sel[13:12], min[11:8], max[7:4], val[3:0]}
  logic [16:0] act;
  assign act = {com_o, osc_o, sel_o, min_o, max_o, val_o};

  localparam logic [16:0] M_REG = 17'h03FFF;
  localparam logic [16:0] M_OSC = 17'h04000;
  localparam logic [16:0] M_COM = 17'h18000;
  localparam logic [16:0] M_ALL = 17'h1FFFF;
  localparam logic [2:0]  P_UP  = 3'b001;
  localparam logic [2:0]  P_DN  = 3'b010;
  localparam logic [2:0]  P_SEL = 3'b100;

  int          q_due[$];
  logic [16:0] q_exp[$];
  logic [16:0] q_msk[$];
  string       q_tag[$];

  logic [16:0] e_vec;

  function automatic logic [16:0] regv(input logic [1:0] s, input logic [3:0] mn,
                                       input logic [3:0] mx, input logic [3:0] v);
    return {2'b00, 1'b0, s, mn, mx, v};
  endfunction

  task automatic push(input int due, input logic [16:0] exp, input logic [16:0] msk,
                      input string tag);
    q_due.push_back(due);
    q_exp.push_back(exp);
    q_msk.push_back(msk);
    q_tag.push_back(tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press the given buttons for 10 cycles; value must hold at +6 and update at +7.
  task automatic press(input logic [2:0] pins, input logic [16:0] nv, input string tag);
    push(cyc + 6, e_vec, M_REG, {tag, "_hold"});
    push(cyc + 7, nv, M_REG, tag);
    {sl, dn, up} = pins;
    tick(10);
    {sl, dn, up} = 3'b000;
    tick(10);
    e_vec = nv;
  endtask

  // Monitor: compare every scoreboard entry due in this cycle, away from the active edge.
  always @(negedge clk) begin
    int mi;
    mi = 0;
    while (mi < q_due.size()) begin
      if (q_due[mi] <= cyc) begin
        checks++;
        if (q_due[mi] < cyc) begin
          errors++;
          $display("FAIL %s missed at cycle %0d (due %0d)", q_tag[mi], cyc, q_due[mi]);
        end else if ((act & q_msk[mi]) !== (q_exp[mi] & q_msk[mi])) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %h, want %h", q_tag[mi], cyc,
                   act & q_msk[mi], q_exp[mi] & q_msk[mi]);
        end
        q_due.delete(mi);
        q_exp.delete(mi);
        q_msk.delete(mi);
        q_tag.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  logic [16:0] rstv;
  int          r_rel;
  int          n0;

  initial begin
    rstv  = regv(2'd0, 4'd0, 4'd15, 4'd0);
    e_vec = rstv;
    #1 rst = 1'b1;
    tick(3);
    push(cyc, rstv, M_ALL, "reset");
    tick(1);
    rst   = 1'b0;
    r_rel = cyc;
    push(r_rel, 17'h0, M_OSC, "osc_pre");
    for (int k = 0; k < 16; k++)
      push(r_rel + 1 + k, ((k % 8) < 2) ? M_OSC : 17'h0, M_OSC, "osc");
    tick(20);

    // Three clean up presses, then a 2-cycle glitch that must be filtered.
    for (int i = 1; i <= 3; i++) press(P_UP, regv(2'd0, 4'd0, 4'd15, 4'(i)), "val_up");
    push(cyc + 7, e_vec, M_REG, "glitch_a");
    push(cyc + 12, e_vec, M_REG, "glitch_b");
    up = 1'b1;
    tick(2);
    up = 1'b0;
    tick(18);

    // Edit max down to 11, then push min up against it.
    press(P_SEL, regv(2'd1, 4'd0, 4'd15, 4'd3), "sel_min");
    press(P_SEL, regv(2'd2, 4'd0, 4'd15, 4'd3), "sel_max");
    for (int i = 1; i <= 4; i++) press(P_DN, regv(2'd2, 4'd0, 4'(15 - i), 4'd3), "max_dn");
    press(P_SEL, regv(2'd0, 4'd0, 4'd11, 4'd3), "sel_val");
    press(P_SEL, regv(2'd1, 4'd0, 4'd11, 4'd3), "sel_min2");
    for (int i = 1; i <= 15; i++)
      press(P_UP, regv(2'd1, 4'((i < 11) ? i : 11), 4'd11, 4'd3), "min_up");
    press(P_SEL, regv(2'd2, 4'd11, 4'd11, 4'd3), "sel_max2");
    for (int i = 0; i < 2; i++) press(P_DN, regv(2'd2, 4'd11, 4'd11, 4'd3), "max_floor");
    press(P_SEL, regv(2'd0, 4'd11, 4'd11, 4'd3), "sel_val2");

    // Value saturation at both ends and same-cycle conflicts.
    for (int i = 4; i <= 15; i++) press(P_UP, regv(2'd0, 4'd11, 4'd11, 4'(i)), "val_up2");
    press(P_UP, regv(2'd0, 4'd11, 4'd11, 4'd15), "val_sat_hi");
    for (int i = 14; i >= 0; i--) press(P_DN, regv(2'd0, 4'd11, 4'd11, 4'(i)), "val_dn");
    press(P_DN, regv(2'd0, 4'd11, 4'd11, 4'd0), "val_sat_lo");
    press(P_UP | P_DN, regv(2'd0, 4'd11, 4'd11, 4'd0), "up_dn_cancel");
    press(P_SEL | P_UP, regv(2'd1, 4'd11, 4'd11, 4'd0), "sel_up");
    press(P_SEL | P_DN, regv(2'd2, 4'd11, 4'd11, 4'd0), "sel_dn");
    press(P_SEL, regv(2'd0, 4'd11, 4'd11, 4'd0), "sel_val3");

    // Mode switches: three-cycle latency, no debounce.
    sw = 2'b11;
    push(cyc + 2, 17'h0, M_COM, "com_pre");
    push(cyc + 3, M_COM, M_COM, "com");
    tick(5);
    sw = 2'b00;
    tick(5);

    // Reset mid-debounce: outputs return immediately, and the press is discarded.
    up = 1'b1;
    tick(4);
    push(cyc, rstv, M_ALL, "async_rst");
    rst = 1'b1;
    up  = 1'b0;
    tick(3);
    rst   = 1'b0;
    e_vec = rstv;
    tick(20);
    push(cyc, rstv, M_REG, "discard");
    tick(1);

    // Button held through reset release: no event until released and pressed again.
    up = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(30);
    push(cyc, rstv, M_REG, "held_rst");
    up = 1'b0;
    tick(20);
    press(P_UP, regv(2'd0, 4'd0, 4'd15, 4'd1), "repress");
    press(P_DN, regv(2'd0, 4'd0, 4'd15, 4'd0), "back_to_0");

    // Long hold of up for 100 cycles from value 0.
    n0 = cyc;
    push(n0 + 6, regv(2'd0, 4'd0, 4'd15, 4'd0), M_REG, "hold_pre");
    push(n0 + 7, regv(2'd0, 4'd0, 4'd15, 4'd1), M_REG, "hold_first");
`ifdef MIN_MAX_CTRL_AUTOREPEAT_EN
    push(n0 + 26, regv(2'd0, 4'd0, 4'd15, 4'd1), M_REG, "rep_pre");
    push(n0 + 27, regv(2'd0, 4'd0, 4'd15, 4'd2), M_REG, "rep_first");
    push(n0 + 37, regv(2'd0, 4'd0, 4'd15, 4'd3), M_REG, "rep_second");
    push(n0 + 120, regv(2'd0, 4'd0, 4'd15, 4'd9), M_REG, "hold_final");
`else
    push(n0 + 60, regv(2'd0, 4'd0, 4'd15, 4'd1), M_REG, "hold_mid");
    push(n0 + 120, regv(2'd0, 4'd0, 4'd15, 4'd1), M_REG, "hold_final");
`endif
    up = 1'b1;
    tick(100);
    up = 1'b0;
    tick(30);

    for (int i = 0; i < 200 && q_due.size() > 0; i++) tick(1);
    if (q_due.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q_due.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
